// File: rtl/gray_alu_scheduler.sv
// Round-robin arbiter that shares one grayALU between two valid/ready requesters and returns
// tagged results. Optional macro GRAY_RESULT_DECODE_EN converts the Gray result to binary at capture.
module gray_alu_scheduler #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_select,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                id_q, id_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic                alu_en_q, alu_en_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic                gnt_any, gnt_id;
  logic [DATA_W-1:0]   cap_result;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;
  end

  // Gated with rst_n so no ready can be seen while reset is asserted.
  assign req0_ready = rst_n && (state_q == StIdle) && gnt_any && !gnt_id;
  assign req1_ready = rst_n && (state_q == StIdle) && gnt_any && gnt_id;

`ifdef GRAY_RESULT_DECODE_EN
  always_comb begin
    cap_result = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      cap_result[i] = ^(alu_result >> i);
    end
  end
`else
  assign cap_result = alu_result;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_en_d     = alu_en_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          alu_a_d   = gnt_id ? req1_a : req0_a;
          alu_b_d   = gnt_id ? req1_b : req0_b;
          alu_sel_d = gnt_id ? req1_sel : req0_sel;
          id_d      = gnt_id;
          alu_en_d  = 1'b1;
          cnt_d     = CntW'(ALU_LAT - 1);
          state_d   = StIssue;
        end
      end
      // The issue cycle already counts toward the latency, so ALU_LAT=1 captures here.
      StIssue, StWait: begin
        if (cnt_q == '0) begin
          rsp_result_d = cap_result;
          rsp_flags_d  = alu_flags;
          rsp_id_d     = id_q;
          alu_en_d     = 1'b0;
          state_d      = StResp;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = StWait;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_d    = ~rsp_id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_en_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_en_q     <= alu_en_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign alu_enable = alu_en_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gray_alu_scheduler.sv
// Bench for gray_alu_scheduler: two DUTs (ALU_LAT 1 and 3), each with a behavioural grayALU,
// checked every cycle against a transaction-timing model plus directed scenario checks.
module tb_gray_alu_scheduler;

  localparam logic [3:0] OpAdd = 4'd0;
`ifdef GRAY_RESULT_DECODE_EN
  localparam logic [7:0] ExpT2 = 8'h08;
  localparam logic [7:0] ExpC0 = 8'h80;
`else
  localparam logic [7:0] ExpT2 = 8'h0C;
  localparam logic [7:0] ExpC0 = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      v0, v1, rdy0, rdy1, alu_en, rsp_v, rsp_rdy, rsp_id, busy;
  logic [1:0][7:0] a0, b0, a1, b1, alu_a, alu_b, alu_res, rsp_res;
  logic [1:0][3:0] s0, s1, alu_sel, alu_flg, rsp_flg;
  bit              force_res;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: one outstanding op per DUT, timed by arithmetic on accept cycle.
  bit   [1:0]      m_pend, m_rr, m_id, g0, g1;
  int              m_t[2];
  logic [1:0][7:0] m_a, m_b;
  logic [1:0][3:0] m_s;

  logic [1:0]      o_rdy0, o_rdy1, o_en, o_rv, o_id, o_busy;
  logic [1:0][7:0] o_res;
  logic [1:0][3:0] o_flg;

  function automatic logic [8:0] alu_f(logic [7:0] a, logic [7:0] b, logic [3:0] s);
    case (s[1:0])
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [7:0] to_gray(logic [7:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [3:0] flags_of(logic [8:0] r);
    return {r[7:0] == 8'd0, r[8], r[7], ^r[7:0]};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned Lat = (k == 0) ? 1 : 3;
    logic [3:0] en_cnt;
    logic [8:0] fr;
    logic [7:0] good;
    logic       win;
    always @(posedge clk) begin
      if (!rst_n || !alu_en[k]) en_cnt <= 4'd0;
      else                      en_cnt <= en_cnt + 4'd1;
    end
    // Result is only correct in the cycle the ALU latency says; garbage otherwise.
    assign fr         = alu_f(alu_a[k], alu_b[k], alu_sel[k]);
    assign good       = force_res ? 8'hC0 : to_gray(fr[7:0]);
    assign win        = alu_en[k] && (en_cnt == 4'(Lat - 1));
    assign alu_res[k] = win ? good : ~good;
    assign alu_flg[k] = win ? flags_of(fr) : ~flags_of(fr);

    gray_alu_scheduler #(.DATA_W(8), .SEL_W(4), .ALU_LAT(Lat)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(v0[k]),
      .req0_ready(rdy0[k]),
      .req0_a    (a0[k]),
      .req0_b    (b0[k]),
      .req0_sel  (s0[k]),
      .req1_valid(v1[k]),
      .req1_ready(rdy1[k]),
      .req1_a    (a1[k]),
      .req1_b    (b1[k]),
      .req1_sel  (s1[k]),
      .alu_a     (alu_a[k]),
      .alu_b     (alu_b[k]),
      .alu_select(alu_sel[k]),
      .alu_enable(alu_en[k]),
      .alu_result(alu_res[k]),
      .alu_flags (alu_flg[k]),
      .rsp_valid (rsp_v[k]),
      .rsp_ready (rsp_rdy[k]),
      .rsp_id    (rsp_id[k]),
      .rsp_result(rsp_res[k]),
      .rsp_flags (rsp_flg[k]),
      .busy      (busy[k])
    );
  end

  task automatic chk(input int k, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(k, {tag, "_ready0"}, rdy0[k], 0);
      chk(k, {tag, "_ready1"}, rdy1[k], 0);
      chk(k, {tag, "_alu_ops"}, {alu_a[k], alu_b[k], alu_sel[k]}, 0);
      chk(k, {tag, "_alu_en"}, alu_en[k], 0);
      chk(k, {tag, "_rsp"}, {rsp_v[k], rsp_id[k], rsp_res[k], rsp_flg[k]}, 0);
      chk(k, {tag, "_busy"}, busy[k], 0);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_rr   = '0;
  endtask

  task automatic model_k(input int k);
    int         lat;
    logic [8:0] fr;
    logic [7:0] er;
    bit         w;
    lat   = (k == 0) ? 1 : 3;
    g0[k] = 1'b0;
    g1[k] = 1'b0;
    if (!m_pend[k]) begin
      chk(k, "idle_busy", busy[k], 0);
      chk(k, "idle_alu_en", alu_en[k], 0);
      chk(k, "idle_rsp_valid", rsp_v[k], 0);
      if (v0[k] || v1[k]) begin
        w         = (v0[k] && v1[k]) ? m_rr[k] : v1[k];
        g0[k]     = !w;
        g1[k]     = w;
        m_pend[k] = 1'b1;
        m_t[k]    = cyc;
        m_id[k]   = w;
        m_a[k]    = w ? a1[k] : a0[k];
        m_b[k]    = w ? b1[k] : b0[k];
        m_s[k]    = w ? s1[k] : s0[k];
      end
      chk(k, "ready0", rdy0[k], g0[k]);
      chk(k, "ready1", rdy1[k], g1[k]);
    end else begin
      chk(k, "busy", busy[k], 1);
      chk(k, "ready0_busy", rdy0[k], 0);
      chk(k, "ready1_busy", rdy1[k], 0);
      chk(k, "alu_enable", alu_en[k], (cyc <= m_t[k] + lat));
      if (cyc <= m_t[k] + lat)
        chk(k, "alu_operands", {alu_a[k], alu_b[k], alu_sel[k]}, {m_a[k], m_b[k], m_s[k]});
      chk(k, "rsp_valid", rsp_v[k], (cyc > m_t[k] + lat));
      if (cyc > m_t[k] + lat) begin
        fr = alu_f(m_a[k], m_b[k], m_s[k]);
        if (force_res) er = ExpC0;
        else begin
`ifdef GRAY_RESULT_DECODE_EN
          er = fr[7:0];
`else
          er = to_gray(fr[7:0]);
`endif
        end
        chk(k, "rsp_id", rsp_id[k], m_id[k]);
        chk(k, "rsp_result", rsp_res[k], er);
        chk(k, "rsp_flags", rsp_flg[k], flags_of(fr));
        if (rsp_rdy[k]) begin
          m_pend[k] = 1'b0;
          m_rr[k]   = !m_id[k];
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_k(k);
      o_rdy0[k] = rdy0[k];
      o_rdy1[k] = rdy1[k];
      o_en[k]   = alu_en[k];
      o_rv[k]   = rsp_v[k];
      o_id[k]   = rsp_id[k];
      o_res[k]  = rsp_res[k];
      o_flg[k]  = rsp_flg[k];
      o_busy[k] = busy[k];
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic rnd_op(input int k, input bit j);
    if (!j) begin
      a0[k] = 8'($urandom); b0[k] = 8'($urandom); s0[k] = 4'($urandom);
    end else begin
      a1[k] = 8'($urandom); b1[k] = 8'($urandom); s1[k] = 4'($urandom);
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    v0 = '0;
    v1 = '0;
    rsp_rdy = 2'b11;
    for (int i = 0; i < 30 && (m_pend != 2'b00); i++) tick();
  endtask

  initial begin
    int gq[$];
    int acc[$];
    int c;
    bit seen;
    logic [7:0] ref_res;
    logic [3:0] ref_flg;

    v0 = '0; v1 = '0; rsp_rdy = '0; force_res = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; s0 = '0; s1 = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD on the ALU_LAT=1 instance: ready@T, enable@T+1, rsp_valid@T+2.
    rsp_rdy = 2'b11;
    v0[0] = 1'b1; a0[0] = 8'h05; b0[0] = 8'h03; s0[0] = OpAdd;
    tick();
    chk(0, "t2_ready_T", o_rdy0[0], 1);
    v0[0] = 1'b0;
    tick();
    chk(0, "t2_enable_T1", o_en[0], 1);
    chk(0, "t2_valid_T1", o_rv[0], 0);
    tick();
    chk(0, "t2_valid_T2", o_rv[0], 1);
    chk(0, "t2_enable_T2", o_en[0], 0);
    chk(0, "t2_id", o_id[0], 0);
    chk(0, "t2_result", o_res[0], ExpT2);
    chk(0, "t2_flags", o_flg[0], 4'b0001);
    tick();
    chk(0, "t2_idle_after", o_busy[0], 0);

    // ALU forced to 8'hC0: decode path visible in rsp_result.
    force_res = 1'b1;
    v1[0] = 1'b1; rnd_op(0, 1'b1);
    tick();
    v1[0] = 1'b0;
    tick();
    tick();
    chk(0, "t6_valid", o_rv[0], 1);
    chk(0, "t6_id", o_id[0], 1);
    chk(0, "t6_result", o_res[0], ExpC0);
    force_res = 1'b0;
    tick();

    // Reset in WAIT on the ALU_LAT=3 instance discards the op.
    v0[1] = 1'b1; rnd_op(1, 1'b0);
    tick();
    v0[1] = 1'b0;
    tick();
    v1[1] = 1'b1;
    v0[0] = 1'b1;
    reset_pulse("t1_mid_wait");
    v0[0] = 1'b0;
    v1[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    v0[1] = 1'b1; v1[1] = 1'b1; rnd_op(1, 1'b0); rnd_op(1, 1'b1);
    tick();
    chk(1, "t1_rr_after_reset", {o_rdy1[1], o_rdy0[1]}, 2'b01);
    v0[1] = 1'b0;
    drain();

    // Contention from reset: grants must alternate 0,1,0,1.
    reset_pulse("t3_reset");
    v0[0] = 1'b1; v1[0] = 1'b1; rnd_op(0, 1'b0); rnd_op(0, 1'b1);
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      tick();
      if (o_rdy0[0]) gq.push_back(0);
      if (o_rdy1[0]) gq.push_back(1);
      if (g0[0]) rnd_op(0, 1'b0);
      if (g1[0]) rnd_op(0, 1'b1);
    end
    chk(0, "t3_grant_count", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) chk(0, $sformatf("t3_grant%0d", i), gq[i], i % 2);
    drain();

    // Backpressure: response held 10 cycles with a waiting requester.
    v1[1] = 1'b1; rnd_op(1, 1'b1);
    rsp_rdy[1] = 1'b0;
    tick();
    v1[1] = 1'b0;
    v0[1] = 1'b1; rnd_op(1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = o_rv[1];
    end
    chk(1, "t4_rsp_seen", seen, 1);
    ref_res = o_res[1];
    ref_flg = o_flg[1];
    for (int i = 0; i < 10; i++) begin
      tick();
      chk(1, "t4_hold_valid", o_rv[1], 1);
      chk(1, "t4_hold_data", {o_id[1], o_res[1], o_flg[1]}, {1'b1, ref_res, ref_flg});
      chk(1, "t4_hold_busy", o_busy[1], 1);
      chk(1, "t4_no_ready", o_rdy0[1], 0);
    end
    rsp_rdy[1] = 1'b1;
    tick();
    chk(1, "t4_complete_valid", o_rv[1], 1);
    tick();
    chk(1, "t4_next_idle", o_busy[1], 0);
    chk(1, "t4_next_accept", o_rdy0[1], 1);
    drain();

    // Response accepted in its first cycle: one op per ALU_LAT+2 = 5 cycles.
    v0[1] = 1'b1; v1[1] = 1'b1; rnd_op(1, 1'b0); rnd_op(1, 1'b1);
    for (int i = 0; i < 40 && acc.size() < 4; i++) begin
      c = cyc;
      tick();
      if (o_rdy0[1] || o_rdy1[1]) acc.push_back(c);
      if (g0[1]) rnd_op(1, 1'b0);
      if (g1[1]) rnd_op(1, 1'b1);
    end
    chk(1, "t5_accept_count", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++)
      chk(1, $sformatf("t5_interval%0d", i), acc[i] - acc[i-1], 5);
    drain();

    // Random traffic with random response backpressure on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        rsp_rdy[k] = ($urandom_range(0, 3) != 0);
        if (!v0[k] && $urandom_range(0, 2) == 0) begin v0[k] = 1'b1; rnd_op(k, 1'b0); end
        if (!v1[k] && $urandom_range(0, 2) == 0) begin v1[k] = 1'b1; rnd_op(k, 1'b1); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (g0[k]) v0[k] = 1'b0;
        if (g1[k]) v1[k] = 1'b0;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
